// File: rtl/ctech_lib_pkg.sv
// ctech_lib_pkg: shared state encoding and parameter range limits for ctech library event cells
package ctech_lib_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} fanout_state_e;
  localparam int unsigned FANOUT_N_MIN = 2;
  localparam int unsigned FANOUT_N_MAX = 16;
  localparam int unsigned FANOUT_W_MIN = 1;
  localparam int unsigned FANOUT_W_MAX = 64;
endpackage

// File: rtl/ctech_lib_event_fanout_branch.sv
// ctech_lib_event_fanout_branch: one consumer branch, holding its done flag and valid/ready handshake
module ctech_lib_event_fanout_branch (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_d_o
);
  logic done_q, done_d;
  assign valid_o  = ~done_q;
  assign done_d_o = done_d;
  // a new token arms enabled branches; an accepted offer retires the branch
  always_comb begin
    done_d = load_i ? ~en_i : (valid_o && ready_i) ? 1'b1 : done_q;
  end
  // done idles high so an idle branch never offers
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b1;
    else     done_q <= done_d;
  end
endmodule

// File: rtl/ctech_lib_event_fanout.sv
// ctech_lib_event_fanout: fork one valid/ready token to N branches; CTECH_LIB_EVENT_FANOUT_CNT_EN adds a delivered-event counter
module ctech_lib_event_fanout
  import ctech_lib_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [N-1:0]  en_mask,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic [CW-1:0] event_cnt
);
  fanout_state_e state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [N-1:0]  done_d;
  logic          accept, final_ack;
  assign accept    = (state_q == IDLE) && in_valid;
  assign final_ack = (state_q == BUSY) && (&done_d);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;
  for (genvar i = 0; i < N; i++) begin : g_branch
    ctech_lib_event_fanout_branch u_branch (
      .clk      (clk),
      .rst      (rst),
      .load_i   (accept),
      .en_i     (en_mask[i]),
      .ready_i  (out_ready[i]),
      .valid_o  (out_valid[i]),
      .done_d_o (done_d[i])
    );
  end
  // an all-zero mask drops the token without leaving IDLE; payload is frozen outside IDLE
  always_comb begin
    state_d = (accept && |en_mask) ? BUSY : final_ack ? IDLE : state_q;
    data_d  = accept ? in_data : data_q;
  end
  // state and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
`ifdef CTECH_LIB_EVENT_FANOUT_CNT_EN
  logic [CW-1:0] cnt_q;
  assign event_cnt = cnt_q;
  // count tokens whose last branch acknowledged; wraps naturally
  always_ff @(posedge clk) begin
    if (rst)            cnt_q <= '0;
    else if (final_ack) cnt_q <= cnt_q + CW'(1);
  end
`else
  assign event_cnt = '0;
`endif
endmodule

// File: tb/tb_ctech_lib_event_fanout.sv
// tb_ctech_lib_event_fanout: directed self-checking bench for the event fanout
module tb_ctech_lib_event_fanout;
  localparam int N = 4, W = 8, CW = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, busy;
  logic [W-1:0] in_data = '0, out_data;
  logic [N-1:0] en_mask = '0, out_valid, out_ready = '0;
  logic [CW-1:0] event_cnt;
  int tests = 0, fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  ctech_lib_event_fanout #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .en_mask(en_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .event_cnt(event_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef CTECH_LIB_EVENT_FANOUT_CNT_EN
    tests++;
    if (event_cnt !== CW'(exp_cnt)) begin
      fails++;
      $display("FAIL %s: event_cnt got %0d expected %0d", name, event_cnt, exp_cnt % (1 << CW));
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_bits("reset in_ready", 64'(in_ready), 64'd1);
    chk_bits("reset out_valid", 64'(out_valid), 64'h0);
    chk_bits("reset busy", 64'(busy), 64'd0);
    chk_bits("reset out_data", 64'(out_data), 64'h0);
    exp_cnt = 0;
    chk_cnt("reset cnt");
    tick();
    chk_bits("idle in_ready", 64'(in_ready), 64'd1);
    chk_bits("idle out_valid", 64'(out_valid), 64'h0);
  endtask

  task automatic test_back_to_back();
    en_mask = 4'b1111;
    out_ready = 4'b1111;
    in_valid = 1'b1;
    in_data = 8'hA5;
    chk_bits("b2b ready0", 64'(in_ready), 64'd1);
    tick();
    chk_bits("b2b ready1", 64'(in_ready), 64'd0);
    chk_bits("b2b valid A5", 64'(out_valid), 64'hF);
    chk_bits("b2b data A5", 64'(out_data), 64'hA5);
    in_data = 8'h3C;
    tick();
    exp_cnt++;
    chk_bits("b2b ready2", 64'(in_ready), 64'd1);
    chk_bits("b2b valid gap", 64'(out_valid), 64'h0);
    tick();
    chk_bits("b2b ready3", 64'(in_ready), 64'd0);
    chk_bits("b2b valid 3C", 64'(out_valid), 64'hF);
    chk_bits("b2b data 3C", 64'(out_data), 64'h3C);
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    chk_bits("b2b idle valid", 64'(out_valid), 64'h0);
    chk_bits("b2b idle ready", 64'(in_ready), 64'd1);
    chk_cnt("b2b cnt");
  endtask

  task automatic test_partial_ack();
    en_mask = 4'b1011;
    out_ready = 4'b0010;
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    en_mask = 4'b0100;
    chk_bits("part valid c1", 64'(out_valid), 64'hB);
    chk_bits("part busy c1", 64'(busy), 64'd1);
    tick();
    out_ready = 4'b0000;
    chk_bits("part valid c2", 64'(out_valid), 64'h9);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk_bits($sformatf("part valid c%0d", c), 64'(out_valid), 64'h9);
      chk_bits($sformatf("part data c%0d", c), 64'(out_data), 64'h5A);
      chk_bits($sformatf("part in_ready c%0d", c), 64'(in_ready), 64'd0);
    end
    out_ready = 4'b1101;
    tick();
    exp_cnt++;
    chk_bits("part valid done", 64'(out_valid), 64'h0);
    chk_bits("part in_ready done", 64'(in_ready), 64'd1);
    chk_bits("part busy done", 64'(busy), 64'd0);
    chk_cnt("part cnt");
    out_ready = 4'b0000;
  endtask

  task automatic test_drop();
    en_mask = 4'b0000;
    in_valid = 1'b1;
    in_data = 8'h11;
    tick();
    chk_bits("drop ready1", 64'(in_ready), 64'd1);
    chk_bits("drop valid1", 64'(out_valid), 64'h0);
    chk_bits("drop busy1", 64'(busy), 64'd0);
    in_valid = 1'b0;
    tick();
    chk_bits("drop ready2", 64'(in_ready), 64'd1);
    chk_bits("drop valid2", 64'(out_valid), 64'h0);
    chk_cnt("drop cnt");
  endtask

  task automatic test_reset_mid_busy();
    en_mask = 4'b1111;
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b0101;
    tick();
    out_ready = 4'b1111;
    chk_bits("rstmid pending", 64'(out_valid), 64'hA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk_bits("rstmid valid", 64'(out_valid), 64'h0);
    chk_bits("rstmid ready", 64'(in_ready), 64'd1);
    chk_bits("rstmid busy", 64'(busy), 64'd0);
    chk_bits("rstmid data", 64'(out_data), 64'h0);
    chk_cnt("rstmid cnt");
    in_valid = 1'b1;
    in_data = 8'h42;
    tick();
    in_valid = 1'b0;
    chk_bits("rstmid next valid", 64'(out_valid), 64'hF);
    chk_bits("rstmid next data", 64'(out_data), 64'h42);
    tick();
    exp_cnt++;
    chk_bits("rstmid next idle", 64'(out_valid), 64'h0);
    chk_cnt("rstmid next cnt");
  endtask

  task automatic test_wrap();
    en_mask = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h80 + i);
      tick();
      in_valid = 1'b0;
      chk_bits($sformatf("wrap data %0d", i), 64'(out_data), 64'(8'h80 + i));
      tick();
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      if (i == 14) chk_cnt("wrap cnt zero");
    end
    chk_cnt("wrap cnt one");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_ack();
    test_drop();
    test_reset_mid_busy();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
